// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter and fill engine.
// Grants one of NUM_CLIENTS requesters per cycle, steers its access onto the
// two BRAM frame buffers, runs a background range fill in idle cycles and
// applies double-buffer flips during vertical blanking.
module fb_write_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_BITS   = 14,
    parameter int DATA_BITS   = 8,
    parameter int ARB_MODE    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CLIENTS-1:0]           client_busy,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] client_addr,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] client_data,
    input  logic [NUM_CLIENTS-1:0]           client_we,
    output logic [NUM_CLIENTS-1:0]           client_grant,
    output logic [DATA_BITS-1:0]             fb_read_data,
    input  logic                             fill_start,
    input  logic [ADDR_BITS-1:0]             fill_base,
    input  logic [ADDR_BITS:0]               fill_len,
    input  logic [DATA_BITS-1:0]             fill_value,
    output logic                             fill_busy,
    output logic                             fill_done,
    input  logic                             flip_req,
    input  logic                             flip_write_buf,
    input  logic                             flip_display_buf,
    input  logic                             vblank,
    output logic                             flip_pending,
    output logic                             write_buffer,
    output logic                             display_buffer,
    output logic [ADDR_BITS-1:0]             fb_a_addr,
    output logic [ADDR_BITS-1:0]             fb_b_addr,
    output logic [DATA_BITS-1:0]             fb_a_data,
    output logic [DATA_BITS-1:0]             fb_b_data,
    output logic                             fb_a_we,
    output logic                             fb_b_we,
    input  logic [DATA_BITS-1:0]             fb_a_rdata,
    input  logic [DATA_BITS-1:0]             fb_b_rdata,
    output logic                             fb_busy
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    // Client index reached by stepping 'offset' places upward from 'base' with wrap.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CLIENTS) sum = sum - NUM_CLIENTS;
        return IDX_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             any_busy;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             owner_hold;
    logic             owner_release;
    logic [IDX_W-1:0] owner_succ;
    logic [IDX_W-1:0] search_start;
    logic [IDX_W-1:0] fp_idx;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] grant_idx;

    // Pick the winner for this cycle under the configured priority mode.
    // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        any_busy      = |client_busy;
        owner_hold    = owner_valid_q && client_busy[owner_q];
        owner_release = owner_valid_q && !client_busy[owner_q];
        owner_succ    = wrap_idx(owner_q, 1);
        // A releasing owner hands the search start to its successor in the same cycle.
        search_start  = owner_release ? owner_succ : ptr_q;

        // Downward scans leave the lowest index / smallest offset as the winner.
        fp_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (client_busy[i]) fp_idx = IDX_W'(i);
        end

        rr_idx = search_start;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (client_busy[wrap_idx(search_start, i)]) rr_idx = wrap_idx(search_start, i);
        end

        if (ARB_MODE == 0) begin
            grant_idx = fp_idx;
        end else begin
            grant_idx = owner_hold ? owner_q : rr_idx;
        end

        client_grant = '0;
        if (any_busy) client_grant[grant_idx] = 1'b1;
    end

    // Round-robin ownership: keep the winner, advance the pointer on release.
    always_comb begin
        owner_valid_d = any_busy;
        owner_d       = any_busy ? grant_idx : owner_q;
        ptr_d         = owner_release ? owner_succ : ptr_q;
    end

    // Round-robin owner and pointer registers.
    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            ptr_q         <= '0;
        end else begin
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            ptr_q         <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Fill engine
    // ------------------------------------------------------------------
    fill_state_t          fill_state_q, fill_state_d;
    logic [ADDR_BITS-1:0] fill_addr_q;
    logic [ADDR_BITS:0]   fill_rem_q;
    logic [DATA_BITS-1:0] fill_val_q;
    logic                 fill_buf_q;
    logic                 fill_write;
    logic                 fill_accept;

    // A start request is only taken from IDLE and with a non-zero length.
    assign fill_accept = (fill_state_q == FILL_IDLE) && fill_start && (fill_len != '0);

    // Fill state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_state_q <= FILL_IDLE;
        end else begin
            fill_state_q <= fill_state_d;
        end
    end

    // Fill next-state: finish on the write that consumes the last byte.
    always_comb begin
        fill_state_d = fill_state_q;
        case (fill_state_q)
            FILL_IDLE: if (fill_accept) fill_state_d = FILL_RUN;
            FILL_RUN:  if (fill_write && (fill_rem_q == (ADDR_BITS+1)'(1))) fill_state_d = FILL_DONE;
            FILL_DONE: fill_state_d = FILL_IDLE;
            default:   fill_state_d = FILL_IDLE;
        endcase
    end

    // Fill outputs: writes only steal cycles nobody else wants.
    always_comb begin
        fill_busy  = (fill_state_q == FILL_RUN);
        fill_done  = (fill_state_q == FILL_DONE);
        fill_write = fill_busy && !any_busy;
    end

    // Fill parameters latched at start; address wraps naturally at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_addr_q <= '0;
            fill_rem_q  <= '0;
            fill_val_q  <= '0;
            fill_buf_q  <= 1'b0;
        end else if (fill_accept) begin
            fill_addr_q <= fill_base;
            fill_rem_q  <= fill_len;
            fill_val_q  <= fill_value;
            fill_buf_q  <= write_buffer;
        end else if (fill_write) begin
            fill_addr_q <= fill_addr_q + 1'b1;
            fill_rem_q  <= fill_rem_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Buffer flip
    // ------------------------------------------------------------------
    logic flip_pending_q;
    logic req_write_q, req_display_q;
    logic write_buffer_q, display_buffer_q;
    logic flip_apply;

    // Flips wait for blanking and for any running fill to complete.
    assign flip_apply = vblank && flip_pending_q && !fill_busy;

    // Flip request latch and buffer-select registers; a coinciding request wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_pending_q   <= 1'b0;
            req_write_q      <= 1'b0;
            req_display_q    <= 1'b0;
            write_buffer_q   <= 1'b0;
            display_buffer_q <= 1'b0;
        end else if (flip_apply) begin
            flip_pending_q   <= 1'b0;
            write_buffer_q   <= flip_req ? flip_write_buf   : req_write_q;
            display_buffer_q <= flip_req ? flip_display_buf : req_display_q;
        end else if (flip_req) begin
            flip_pending_q   <= 1'b1;
            req_write_q      <= flip_write_buf;
            req_display_q    <= flip_display_buf;
        end
    end

    assign flip_pending   = flip_pending_q;
    assign write_buffer   = write_buffer_q;
    assign display_buffer = display_buffer_q;

    // ------------------------------------------------------------------
    // BRAM datapath
    // ------------------------------------------------------------------
    logic [ADDR_BITS-1:0] bus_addr;
    logic [DATA_BITS-1:0] bus_data;
    logic                 bus_we;
    logic                 bus_side;

    // Steer the granted client, else the fill engine; the bus is held quiet during reset.
    always_comb begin
        bus_addr = '0;
        bus_data = '0;
        bus_we   = 1'b0;
        bus_side = 1'b0;
        if (!reset) begin
            if (any_busy) begin
                bus_addr = client_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
                bus_data = client_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
                bus_we   = client_we[grant_idx];
                bus_side = write_buffer_q;
            end else if (fill_write) begin
                bus_addr = fill_addr_q;
                bus_data = fill_val_q;
                bus_we   = 1'b1;
                bus_side = fill_buf_q;
            end
        end
    end

    assign fb_a_addr    = bus_addr;
    assign fb_b_addr    = bus_addr;
    assign fb_a_data    = bus_data;
    assign fb_b_data    = bus_data;
    assign fb_a_we      = bus_we && !bus_side;
    assign fb_b_we      = bus_we && bus_side;
    assign fb_read_data = write_buffer_q ? fb_b_rdata : fb_a_rdata;
    assign fb_busy      = any_busy | fill_busy | flip_pending_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: one fixed-priority and one
// round-robin instance driven by shared stimulus, compared against a
// cycle-level behavioural model and a byte-array picture of both buffers.
module tb_fb_write_arbiter;

    localparam int N  = 4;
    localparam int AB = 14;
    localparam int DB = 8;
    localparam int MEM = 1 << AB;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]    client_busy;
    logic [N*AB-1:0] client_addr;
    logic [N*DB-1:0] client_data;
    logic [N-1:0]    client_we;
    logic            fill_start;
    logic [AB-1:0]   fill_base;
    logic [AB:0]     fill_len;
    logic [DB-1:0]   fill_value;
    logic            flip_req, flip_write_buf, flip_display_buf, vblank;
    logic [DB-1:0]   fb_a_rdata, fb_b_rdata;

    logic [N-1:0]  g0, g1;
    logic [DB-1:0] rd0, rd1;
    logic          fbusy0, fdone0, fpend0, wb0, db0, busy0;
    logic          fbusy1, fdone1, fpend1, wb1, db1, busy1;
    logic [AB-1:0] a_addr0, b_addr0, a_addr1, b_addr1;
    logic [DB-1:0] a_data0, b_data0, a_data1, b_data1;
    logic          a_we0, b_we0, a_we1, b_we1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(.NUM_CLIENTS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .ARB_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .client_busy(client_busy), .client_addr(client_addr),
        .client_data(client_data), .client_we(client_we), .client_grant(g0), .fb_read_data(rd0),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
        .fill_busy(fbusy0), .fill_done(fdone0), .flip_req(flip_req), .flip_write_buf(flip_write_buf),
        .flip_display_buf(flip_display_buf), .vblank(vblank), .flip_pending(fpend0),
        .write_buffer(wb0), .display_buffer(db0), .fb_a_addr(a_addr0), .fb_b_addr(b_addr0),
        .fb_a_data(a_data0), .fb_b_data(b_data0), .fb_a_we(a_we0), .fb_b_we(b_we0),
        .fb_a_rdata(fb_a_rdata), .fb_b_rdata(fb_b_rdata), .fb_busy(busy0));

    fb_write_arbiter #(.NUM_CLIENTS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .ARB_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .client_busy(client_busy), .client_addr(client_addr),
        .client_data(client_data), .client_we(client_we), .client_grant(g1), .fb_read_data(rd1),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
        .fill_busy(fbusy1), .fill_done(fdone1), .flip_req(flip_req), .flip_write_buf(flip_write_buf),
        .flip_display_buf(flip_display_buf), .vblank(vblank), .flip_pending(fpend1),
        .write_buffer(wb1), .display_buffer(db1), .fb_a_addr(a_addr1), .fb_b_addr(b_addr1),
        .fb_a_data(a_data1), .fb_b_data(b_data1), .fb_a_we(a_we1), .fb_b_we(b_we1),
        .fb_a_rdata(fb_a_rdata), .fb_b_rdata(fb_b_rdata), .fb_busy(busy1));

    // Buffer contents as written by the fixed-priority instance, and as they should be.
    logic [DB-1:0] act_a [MEM];
    logic [DB-1:0] act_b [MEM];
    logic [DB-1:0] exp_a [MEM];
    logic [DB-1:0] exp_b [MEM];

    // Behavioural model state.
    bit            m_wbuf, m_dbuf, m_pend, m_rw, m_rd, m_run, m_done, m_fbuf;
    logic [AB-1:0] m_faddr;
    int            m_frem;
    logic [DB-1:0] m_fval;
    int            m_owner, m_ptr;

    // Expected combinational view for the current cycle.
    bit            e_any, e_fw;
    logic [N-1:0]  e_g0, e_g1;
    int            gi0, gi1;
    bit            e_a_we, e_b_we, e1_a_we, e1_b_we;
    logic [AB-1:0] e_addr, e1_addr;
    logic [DB-1:0] e_data, e1_data;

    task automatic model_reset();
        m_wbuf = 0; m_dbuf = 0; m_pend = 0; m_rw = 0; m_rd = 0;
        m_run = 0; m_done = 0; m_fbuf = 0; m_faddr = '0; m_frem = 0; m_fval = '0;
        m_owner = -1; m_ptr = 0;
    endtask

    task automatic drive_route(input int gi, output bit awe, output bit bwe,
                               output logic [AB-1:0] addr, output logic [DB-1:0] data);
        bit we, side;
        we = 0; side = 0; addr = '0; data = '0;
        if (e_any) begin
            we = client_we[gi]; side = m_wbuf;
            addr = client_addr[gi*AB +: AB]; data = client_data[gi*DB +: DB];
        end else if (e_fw) begin
            we = 1; side = m_fbuf; addr = m_faddr; data = m_fval;
        end
        awe = we && !side;
        bwe = we && side;
    endtask

    task automatic model_comb();
        int start, idx;
        e_any = |client_busy;
        gi0 = 0;
        for (int i = N - 1; i >= 0; i--) if (client_busy[i]) gi0 = i;
        if (m_owner >= 0 && client_busy[m_owner]) begin
            gi1 = m_owner;
        end else begin
            start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
            gi1 = start;
            for (int k = N - 1; k >= 0; k--) begin
                idx = (start + k) % N;
                if (client_busy[idx]) gi1 = idx;
            end
        end
        e_g0 = '0; e_g1 = '0;
        if (e_any) begin e_g0[gi0] = 1'b1; e_g1[gi1] = 1'b1; end
        e_fw = m_run && !e_any;
        drive_route(gi0, e_a_we, e_b_we, e_addr, e_data);
        drive_route(gi1, e1_a_we, e1_b_we, e1_addr, e1_data);
    endtask

    task automatic eval();
        #1;
        model_comb();
    endtask

    // Advance the model across the coming rising edge, then move to the next falling edge.
    task automatic tick();
        bit run_o, done_o;
        model_comb();
        if (a_we0) act_a[a_addr0] = a_data0;
        if (b_we0) act_b[b_addr0] = b_data0;
        if (e_a_we) exp_a[e_addr] = e_data;
        if (e_b_we) exp_b[e_addr] = e_data;
        if (m_owner >= 0 && !client_busy[m_owner]) m_ptr = (m_owner + 1) % N;
        m_owner = e_any ? gi1 : -1;
        run_o = m_run; done_o = m_done;
        if (done_o) m_done = 0;
        if (run_o && e_fw) begin
            m_faddr = m_faddr + 1'b1;
            m_frem  = m_frem - 1;
            if (m_frem == 0) begin m_run = 0; m_done = 1; end
        end
        if (!run_o && !done_o && fill_start && fill_len != 0) begin
            m_run = 1; m_faddr = fill_base; m_frem = int'(fill_len); m_fval = fill_value; m_fbuf = m_wbuf;
        end
        if (vblank && m_pend && !run_o) begin
            m_wbuf = flip_req ? flip_write_buf : m_rw;
            m_dbuf = flip_req ? flip_display_buf : m_rd;
            m_pend = 0;
        end else if (flip_req) begin
            m_rw = flip_write_buf; m_rd = flip_display_buf; m_pend = 1;
        end
        @(negedge clk);
    endtask

    task automatic set_client(input int i, input bit busy, input logic [AB-1:0] addr,
                              input logic [DB-1:0] data, input bit we);
        client_busy[i] = busy;
        client_addr[i*AB +: AB] = addr;
        client_data[i*DB +: DB] = data;
        client_we[i] = we;
    endtask

    task automatic clear_inputs();
        client_busy = '0; client_addr = '0; client_data = '0; client_we = '0;
        fill_start = 0; fill_base = '0; fill_len = '0; fill_value = '0;
        flip_req = 0; flip_write_buf = 0; flip_display_buf = 0; vblank = 0;
        fb_a_rdata = '0; fb_b_rdata = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        set_client(0, 1, 14'h1234, 8'h5A, 1);
        @(negedge clk);
        #1;
        total++;
        if ({a_we0, b_we0, a_addr0, b_addr0, a_data0, b_data0} !== '0) begin
            bad++; $display("FAIL reset_bus got=%0h exp=0", {a_we0, b_we0, a_addr0, b_addr0, a_data0, b_data0});
        end
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        model_reset();
        eval();
        total++;
        if ({fbusy0, fdone0, fpend0, wb0, db0, busy0, fbusy1, fpend1} !== 8'b0) begin
            bad++; $display("FAIL reset_status got=%b exp=00000000", {fbusy0, fdone0, fpend0, wb0, db0, busy0, fbusy1, fpend1});
        end
        total++;
        if ({g0, g1} !== '0) begin
            bad++; $display("FAIL reset_grant got=%0h exp=0", {g0, g1});
        end
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        set_client(1, 1, 14'h0010, 8'h11, 1);
        set_client(3, 1, 14'h0020, 8'h33, 1);
        eval();
        total++;
        if ({g0, a_we0, b_we0, a_addr0} !== {4'b0010, 1'b1, 1'b0, 14'h0010}) begin
            bad++; $display("FAIL fp_two_busy got=%0h exp=%0h", {g0, a_we0, b_we0, a_addr0}, {4'b0010, 1'b1, 1'b0, 14'h0010});
        end
        tick();
        set_client(1, 0, 14'h0010, 8'h11, 1);
        eval();
        total++;
        if ({g0, a_addr0, a_data0} !== {4'b1000, 14'h0020, 8'h33}) begin
            bad++; $display("FAIL fp_drop got=%0h exp=%0h", {g0, a_addr0, a_data0}, {4'b1000, 14'h0020, 8'h33});
        end
        tick();
        set_client(0, 1, 14'h0005, 8'h77, 0);
        eval();
        total++;
        if ({g0, a_we0, a_addr0} !== {4'b0001, 1'b0, 14'h0005}) begin
            bad++; $display("FAIL fp_preempt got=%0h exp=%0h", {g0, a_we0, a_addr0}, {4'b0001, 1'b0, 14'h0005});
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        int cnt, last_model, last_seen, seen;
        logic [N-1:0] drop;
        int exp_order[4] = '{0, 1, 2, 0};
        apply_reset();
        drop = '0; cnt = 0; last_model = -1; last_seen = -1;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 3; i++) set_client(i, !drop[i], AB'(16'h0100 * i + c), DB'(c), 1);
            eval();
            total++;
            if (g1 !== e_g1) begin
                bad++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, g1, e_g1);
            end
            seen = -1;
            for (int i = 0; i < N; i++) if (g1[i]) seen = i;
            if (seen >= 0 && seen != last_seen) begin order.push_back(seen); last_seen = seen; end
            if (gi1 == last_model) cnt++; else cnt = 1;
            last_model = gi1;
            drop = '0;
            if (cnt == 3) begin drop[gi1] = 1'b1; cnt = 0; end
            tick();
        end
        client_busy = '0;
        total++;
        if (order.size() < 4) begin
            bad++; $display("FAIL rr_order_len got=%0d exp>=4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (order[k] != exp_order[k]) begin
                    bad++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, order[k], exp_order[k]);
                    break;
                end
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [AB-1:0] got[$];
        logic [AB-1:0] exp_q[4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        int a_hits, data_bad, dones;
        apply_reset();
        flip_req = 1; flip_write_buf = 1; flip_display_buf = 0; vblank = 1;
        eval(); tick();
        flip_req = 0;
        eval(); tick();
        vblank = 0;
        eval();
        total++;
        if (wb0 !== 1'b1) begin
            bad++; $display("FAIL wrap_setup_wbuf got=%b exp=1", wb0);
        end
        fill_base = 14'h3FFE; fill_len = 15'd4; fill_value = 8'hA5; fill_start = 1;
        eval(); tick();
        fill_start = 0;
        a_hits = 0; data_bad = 0; dones = 0;
        for (int c = 0; c < 10; c++) begin
            eval();
            if (b_we0) begin got.push_back(b_addr0); if (b_data0 !== 8'hA5) data_bad++; end
            if (a_we0) a_hits++;
            if (fdone0) dones++;
            tick();
        end
        total++;
        if (got.size() != 4) begin
            bad++; $display("FAIL wrap_count got=%0d exp=4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (got[k] !== exp_q[k]) begin
                    bad++; $display("FAIL wrap_addr k=%0d got=%0h exp=%0h", k, got[k], exp_q[k]);
                    break;
                end
            end
        end
        total++;
        if ({a_hits, data_bad, dones} !== {32'd0, 32'd0, 32'd1}) begin
            bad++; $display("FAIL wrap_side_data_done got=%0d/%0d/%0d exp=0/0/1", a_hits, data_bad, dones);
        end
    endtask

    task automatic test_fill_contention();
        logic [DB-1:0] cdata[10];
        logic [DB-1:0] fv;
        int fill_writes, intrude, done_cycle, region_bad, client_bad, mem_bad;
        apply_reset();
        fv = DB'($urandom);
        fill_base = 14'h0100; fill_len = 15'd8000; fill_value = fv;
        fill_writes = 0; intrude = 0; done_cycle = -1;
        for (int c = 0; c < 8100 && done_cycle < 0; c++) begin
            fill_start = (c == 0);
            if (c >= 10 && c <= 19) begin
                cdata[c-10] = DB'($urandom);
                set_client(2, 1, AB'(16'h3000 + c), cdata[c-10], 1);
            end else begin
                set_client(2, 0, '0, '0, 0);
            end
            eval();
            if (client_busy == '0 && a_we0) fill_writes++;
            if (client_busy != '0 && (a_addr0 !== AB'(16'h3000 + c) || a_data0 !== cdata[c-10] || b_we0)) intrude++;
            if (fdone0) done_cycle = c;
            tick();
        end
        fill_start = 0;
        total++;
        if (fill_writes != 8000) begin
            bad++; $display("FAIL cont_fill_writes got=%0d exp=8000", fill_writes);
        end
        total++;
        if (intrude != 0) begin
            bad++; $display("FAIL cont_intrude got=%0d exp=0", intrude);
        end
        total++;
        if (done_cycle != 8011) begin
            bad++; $display("FAIL cont_done_cycle got=%0d exp=8011", done_cycle);
        end
        region_bad = 0; client_bad = 0; mem_bad = 0;
        for (int k = 0; k < 8000; k++) if (act_a[16'h0100 + k] !== fv) region_bad++;
        for (int k = 0; k < 10; k++) if (act_a[16'h3000 + 10 + k] !== cdata[k]) client_bad++;
        for (int k = 0; k < MEM; k++) if (act_a[k] !== exp_a[k] || act_b[k] !== exp_b[k]) mem_bad++;
        total++;
        if ({region_bad, client_bad, mem_bad} !== 96'd0) begin
            bad++; $display("FAIL cont_memory got=%0d/%0d/%0d exp=0/0/0", region_bad, client_bad, mem_bad);
        end
    endtask

    task automatic test_flip();
        apply_reset();
        for (int c = 0; c <= 51; c++) begin
            flip_req = (c == 0 || c == 5);
            flip_write_buf = (c == 0);
            flip_display_buf = 1;
            vblank = (c >= 50);
            eval();
            if (c == 50) begin
                total++;
                if ({fpend0, wb0, db0} !== 3'b100) begin
                    bad++; $display("FAIL flip_wait got=%b exp=100", {fpend0, wb0, db0});
                end
            end
            if (c == 51) begin
                total++;
                if ({wb0, db0, fpend0} !== 3'b010) begin
                    bad++; $display("FAIL flip_apply got=%b exp=010", {wb0, db0, fpend0});
                end
            end
            tick();
        end
        flip_req = 0; vblank = 0;
    endtask

    task automatic test_random();
        int cyc_bad;
        int mem_bad;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                set_client(i, $urandom_range(0, 9) < 2, AB'($urandom), DB'($urandom), 1'($urandom));
            fill_start = ($urandom_range(0, 19) == 0);
            fill_base = AB'($urandom);
            fill_len = (AB+1)'($urandom_range(0, 30));
            fill_value = DB'($urandom);
            flip_req = ($urandom_range(0, 29) == 0);
            flip_write_buf = 1'($urandom);
            flip_display_buf = 1'($urandom);
            if ($urandom_range(0, 9) == 0) vblank = ~vblank;
            fb_a_rdata = DB'($urandom);
            fb_b_rdata = DB'($urandom);
            eval();
            cyc_bad = 0;
            total++;
            if ({g0, g1} !== {e_g0, e_g1}) begin
                cyc_bad++; $display("FAIL rnd_grant c=%0d got=%0h exp=%0h", c, {g0, g1}, {e_g0, e_g1});
            end
            total++;
            if ({a_we0, b_we0, a_we1, b_we1} !== {e_a_we, e_b_we, e1_a_we, e1_b_we}) begin
                cyc_bad++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, {a_we0, b_we0, a_we1, b_we1}, {e_a_we, e_b_we, e1_a_we, e1_b_we});
            end
            if (e_any || e_fw) begin
                total++;
                if ({a_addr0, b_addr0, a_data0, b_data0, a_addr1, a_data1} !== {e_addr, e_addr, e_data, e_data, e1_addr, e1_data}) begin
                    cyc_bad++; $display("FAIL rnd_bus c=%0d got=%0h exp=%0h", c, {a_addr0, b_addr0, a_data0, b_data0, a_addr1, a_data1}, {e_addr, e_addr, e_data, e_data, e1_addr, e1_data});
                end
            end
            total++;
            if ({fbusy0, fdone0, fpend0, wb0, db0, busy0} !== {m_run, m_done, m_pend, m_wbuf, m_dbuf, e_any | m_run | m_pend} ||
                {fbusy1, fdone1, fpend1, wb1, db1, busy1} !== {m_run, m_done, m_pend, m_wbuf, m_dbuf, e_any | m_run | m_pend}) begin
                cyc_bad++; $display("FAIL rnd_status c=%0d got=%b/%b exp=%b", c, {fbusy0, fdone0, fpend0, wb0, db0, busy0}, {fbusy1, fdone1, fpend1, wb1, db1, busy1}, {m_run, m_done, m_pend, m_wbuf, m_dbuf, e_any | m_run | m_pend});
            end
            total++;
            if ({rd0, rd1} !== {2{m_wbuf ? fb_b_rdata : fb_a_rdata}}) begin
                cyc_bad++; $display("FAIL rnd_rdata c=%0d got=%0h exp=%0h", c, {rd0, rd1}, {2{m_wbuf ? fb_b_rdata : fb_a_rdata}});
            end
            bad += cyc_bad;
            tick();
        end
        clear_inputs();
        for (int c = 0; c < 200; c++) begin eval(); tick(); end
        mem_bad = 0;
        for (int k = 0; k < MEM; k++) if (act_a[k] !== exp_a[k] || act_b[k] !== exp_b[k]) mem_bad++;
        total++;
        if (mem_bad != 0) begin
            bad++; $display("FAIL rnd_memory got=%0d exp=0", mem_bad);
        end
    endtask

    task automatic test_reset_midfill();
        int dones;
        apply_reset();
        flip_req = 1; flip_write_buf = 1; flip_display_buf = 1; vblank = 0;
        eval(); tick();
        flip_req = 0;
        fill_base = AB'($urandom); fill_len = 15'd100; fill_value = 8'h3C; fill_start = 1;
        eval(); tick();
        fill_start = 0;
        repeat (5) begin eval(); tick(); end
        eval();
        total++;
        if ({fbusy0, a_we0, fpend0} !== 3'b111) begin
            bad++; $display("FAIL midfill_pre got=%b exp=111", {fbusy0, a_we0, fpend0});
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({fbusy0, a_we0, b_we0, fpend0, fdone0, fbusy1, fpend1} !== 7'b0) begin
            bad++; $display("FAIL midfill_async got=%b exp=0000000", {fbusy0, a_we0, b_we0, fpend0, fdone0, fbusy1, fpend1});
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        dones = 0;
        for (int c = 0; c < 120; c++) begin
            eval();
            if (fdone0 || fbusy0 || fdone1) dones++;
            tick();
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL midfill_no_done got=%0d exp=0", dones);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < MEM; k++) begin
            act_a[k] = '0; act_b[k] = '0; exp_a[k] = '0; exp_b[k] = '0;
        end
        model_reset();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_fill_wrap();
        test_fill_contention();
        test_flip();
        test_random();
        test_reset_midfill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
